fir_smpl_queue: RTL and testbench
=================================

Name: fir_smpl_queue

Overview:
- Dual-channel (left/right) circular sample queue that feeds the FIR band filters.
- Stores each incoming 16-bit stereo sample.
- Once the queue holds a full filter window, every new sample triggers a readout of the last TAPS samples, oldest to newest, one pair per clock.
- `sequencing` is held high for exactly TAPS cycles during readout. The FIR bands use it to clear and accumulate.

Parameters:
- DEPTH, 1024: queue entries per channel; power of 2; must exceed TAPS.
- TAPS, 1021: samples per readout window (the FIR coefficient count).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wrt_smpl  input  1  one-cycle strobe: lft_smpl/rght_smpl valid
- lft_smpl  input  16  left sample in (signed)
- rght_smpl  input  16  right sample in (signed)
- sequencing  output  1  high while a readout window is presented
- lft_out  output  16  left sample to FIR bands
- rght_out  output  16  right sample to FIR bands
- ovrrun  output  1  one-cycle pulse: wrt_smpl arrived during a readout and was dropped

Behaviour:
- Clocking and reset:
  - Single clock domain; all state flops clear asynchronously on rst_n low.
- Reset values:
  - sequencing=0, lft_out=0, rght_out=0, ovrrun=0.
  - Write pointer new_ptr=0, oldest pointer old_ptr=0, fill count=0, FSM=IDLE.
- Storage:
  - Two DEPTH x 16 arrays with a registered (1-cycle) read port; storage contents are not reset.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Write (accepted only in IDLE):
  - On wrt_smpl: write both samples at new_ptr, then new_ptr+=1.
  - If count<TAPS: count+=1. Otherwise old_ptr+=1, discarding the oldest sample so the window stays TAPS wide.
- Readout trigger:
  - A write that leaves count==TAPS after its update starts a readout. The TAPS-th write is the first trigger; every later write also triggers.
  - Writes 1..TAPS-1 after reset never assert sequencing.
- FSM states:
  - IDLE -> PRIME on a triggering write: rd_ptr<=old_ptr (post-update value).
  - PRIME (1 cycle): issue read at rd_ptr, rd_ptr+=1 -> READ.
  - READ: data registered from the previous read address drives lft_out/rght_out. sequencing=1. Issue the next read, rd_ptr+=1, remaining-counter decrements.
  - READ -> IDLE after exactly TAPS cycles in READ.
- Latency:
  - wrt_smpl high in cycle T → sequencing high in cycles T+3 .. T+2+TAPS.
  - Readout k (k=0..TAPS-1) presents the entry at old_ptr+k in cycle T+3+k.
  - Readout k=0 is the oldest sample; k=TAPS-1 is the sample written at T.
- Outputs:
  - lft_out/rght_out hold their last read value while sequencing=0.
  - sequencing deasserts in the cycle after the last sample.
  - Back-to-back windows are separated by at least one IDLE cycle.
- Overrun:
  - wrt_smpl while in PRIME or READ: sample not written, pointers/count unchanged, ovrrun=1 for that cycle.
  - The current readout continues unaffected.
  - The system guarantees a sample period of at least TAPS+3 clocks; ovrrun flags violations only.
- Readout wrap-around:
  - When old_ptr+k crosses DEPTH-1 it wraps to 0 with no gap or stall.
- Write in the IDLE cycle right after READ ends is legal and accepted normally.
- Reset mid-operation:
  - Readout aborts immediately; sequencing drops asynchronously.
  - count=0, so the next TAPS-1 writes refill without triggering a readout.

Test Plan:
- Reset check: assert rst_n=0 during READ → sequencing=0, lft_out=rght_out=0, ovrrun=0 immediately. The next 1020 writes produce no sequencing.
- Fill phase (defaults): write samples L=i, R=-i for i=1..1020 → sequencing stays 0. Write i=1021 at cycle T → sequencing high T+3..T+1023. lft_out=1..1021 and rght_out=-1..-1021 in order.
- Sliding window: continue with write i=1022 → next window presents lft_out 2..1022. Exactly 1021 high cycles of sequencing; outputs hold 1022 afterwards.
- Wrap-around (DEPTH=8, TAPS=5): write L=10..21 spaced 10 cycles apart. Window after 21 presents 17,18,19,20,21. Pointer wrap at address 7→0 shows no bubble in sequencing.
- Overrun (DEPTH=8, TAPS=5): after full, write 30, then write 31 two cycles into READ → ovrrun single-cycle pulse. The window still shows the five samples ending in 30. The next write 32 yields a window ending ...,30,32.
- Simultaneous boundary (DEPTH=8, TAPS=5): wrt_smpl in the first IDLE cycle after sequencing falls → accepted (no ovrrun). A new window starts 3 cycles later.

Source files
------------

// File: rtl/fir_smpl_queue.sv
// Dual-channel circular sample queue feeding the FIR bands: stores stereo samples and,
// once a full TAPS-wide window is held, replays it oldest-to-newest on every new sample.
module fir_smpl_queue #(
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt_smpl,
  input  logic [15:0] lft_smpl,
  input  logic [15:0] rght_smpl,
  output logic        sequencing,
  output logic [15:0] lft_out,
  output logic [15:0] rght_out,
  output logic        ovrrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0] TAPS_C  = CW'(TAPS);
  localparam logic [CW-1:0] TAPS_M1 = CW'(TAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    READ  = 2'b10
  } state_t;

  state_t state_r, state_nxt_s;

  logic [15:0]   mem_l [DEPTH];
  logic [15:0]   mem_r [DEPTH];
  logic [15:0]   rd_lft_r, rd_rght_r;
  logic [AW-1:0] new_ptr_r, old_ptr_r, rd_ptr_r, old_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s, rem_r;
  logic          wr_acc_s, trig_s, rd_en_s;
  logic          seq_r, ovrrun_r;
  logic [15:0]   lft_out_r, rght_out_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: writes only land in IDLE; PRIME and READ both issue reads
  always_comb begin
    state_nxt_s = state_r;
    wr_acc_s    = 1'b0;
    trig_s      = 1'b0;
    rd_en_s     = 1'b0;
    case (state_r)
      IDLE: begin
        wr_acc_s = wrt_smpl;
        if (wrt_smpl && (cnt_r >= TAPS_M1)) begin
          trig_s      = 1'b1;
          state_nxt_s = PRIME;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRIME: begin
        rd_en_s     = 1'b1;
        state_nxt_s = READ;
      end
      READ: begin
        rd_en_s = 1'b1;
        if (rem_r == {CW{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = READ;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Window bookkeeping: grow until TAPS wide, then slide the oldest pointer
  always_comb begin
    old_nxt_s = old_ptr_r;
    cnt_nxt_s = cnt_r;
    if (wr_acc_s) begin
      if (cnt_r < TAPS_C) begin
        cnt_nxt_s = cnt_r + CW'(1);
      end else begin
        old_nxt_s = old_ptr_r + AW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Pointer, fill count and readout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr_r <= {AW{1'b0}};
      old_ptr_r <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      rem_r     <= {CW{1'b0}};
    end else begin
      old_ptr_r <= old_nxt_s;
      cnt_r     <= cnt_nxt_s;
      if (wr_acc_s) begin
        new_ptr_r <= new_ptr_r + AW'(1);
      end
      if (trig_s) begin
        rd_ptr_r <= old_nxt_s;
      end else if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (state_r == PRIME) begin
        rem_r <= TAPS_M1;
      end else if ((state_r == READ) && (rem_r != {CW{1'b0}})) begin
        rem_r <= rem_r - CW'(1);
      end
    end
  end

  // Sample storage with a one-cycle registered read port; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_l[new_ptr_r] <= lft_smpl;
      mem_r[new_ptr_r] <= rght_smpl;
    end
    if (rd_en_s) begin
      rd_lft_r  <= mem_l[rd_ptr_r];
      rd_rght_r <= mem_r[rd_ptr_r];
    end
  end

  // Output stage: present read data during READ, otherwise hold the last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_r      <= 1'b0;
      lft_out_r  <= 16'h0000;
      rght_out_r <= 16'h0000;
      ovrrun_r   <= 1'b0;
    end else begin
      ovrrun_r <= wrt_smpl && (state_r != IDLE);
      if (state_r == READ) begin
        seq_r      <= 1'b1;
        lft_out_r  <= rd_lft_r;
        rght_out_r <= rd_rght_r;
      end else begin
        seq_r <= 1'b0;
      end
    end
  end

  assign sequencing = seq_r;
  assign lft_out    = lft_out_r;
  assign rght_out   = rght_out_r;
  assign ovrrun     = ovrrun_r;

endmodule

// File: tb/tb_fir_smpl_queue.sv
// Directed bench for fir_smpl_queue: a default-size instance for fill/slide/reset
// and a DEPTH=8, TAPS=5 instance for wrap-around, overrun and back-to-back windows.
module tb_fir_smpl_queue;

  localparam int TAPS   = 1021;
  localparam int S_TAPS = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt, s_wrt;
  logic [15:0] lft, rght, s_lft, s_rght;
  logic        seq, s_seq, ovr, s_ovr;
  logic [15:0] lout, rout, s_lout, s_rout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fir_smpl_queue u_dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt), .lft_smpl(lft), .rght_smpl(rght),
    .sequencing(seq), .lft_out(lout), .rght_out(rout), .ovrrun(ovr)
  );

  fir_smpl_queue #(.DEPTH(8), .TAPS(S_TAPS)) u_small (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(s_wrt), .lft_smpl(s_lft), .rght_smpl(s_rght),
    .sequencing(s_seq), .lft_out(s_lout), .rght_out(s_rout), .ovrrun(s_ovr)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_big(input int v);
    wrt  = 1'b1;
    lft  = 16'(v);
    rght = -16'(v);
    step();
    wrt  = 1'b0;
  endtask

  task automatic wr_small(input int v);
    s_wrt  = 1'b1;
    s_lft  = 16'(v);
    s_rght = 16'(v + 100);
    step();
    s_wrt  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (seq !== 1'b0 || lout !== 16'h0000 || rout !== 16'h0000 || ovr !== 1'b0)
      $display("FAIL reset_big: seq=%b l=%h r=%h ovr=%b, want 0/0000/0000/0", seq, lout, rout, ovr);
    checks++;
    if (s_seq !== 1'b0 || s_lout !== 16'h0000 || s_rout !== 16'h0000 || s_ovr !== 1'b0)
      $display("FAIL reset_small: seq=%b l=%h r=%h ovr=%b, want 0/0000/0000/0", s_seq, s_lout, s_rout, s_ovr);
    if (seq !== 1'b0 || lout !== 16'h0000 || rout !== 16'h0000 || ovr !== 1'b0) errors++;
    if (s_seq !== 1'b0 || s_lout !== 16'h0000 || s_rout !== 16'h0000 || s_ovr !== 1'b0) errors++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill;
    logic [15:0] e;
    for (int i = 1; i < TAPS; i++) begin
      wr_big(i);
      checks++;
      if (seq !== 1'b0) begin errors++; $display("FAIL fill_seq_a i=%0d: seq=%b want 0", i, seq); end
      step();
      checks++;
      if (seq !== 1'b0) begin errors++; $display("FAIL fill_seq_b i=%0d: seq=%b want 0", i, seq); end
    end
    wr_big(TAPS);
    checks++;
    if (seq !== 1'b0) begin errors++; $display("FAIL fill_t1: seq=%b want 0", seq); end
    step();
    checks++;
    if (seq !== 1'b0) begin errors++; $display("FAIL fill_t2: seq=%b want 0", seq); end
    for (int k = 0; k < TAPS; k++) begin
      step();
      e = 16'(k + 1);
      checks++;
      if (seq !== 1'b1 || lout !== e || rout !== -e) begin
        errors++;
        $display("FAIL fill_win k=%0d: seq=%b l=%h r=%h, want 1/%h/%h", k, seq, lout, rout, e, -e);
      end
    end
    step();
    checks++;
    if (seq !== 1'b0 || lout !== 16'(TAPS)) begin
      errors++; $display("FAIL fill_end: seq=%b l=%h, want 0/%h", seq, lout, 16'(TAPS));
    end
  endtask

  task automatic test_sliding;
    logic [15:0] e;
    int high;
    high = 0;
    wr_big(TAPS + 1);
    step();
    for (int k = 0; k < TAPS; k++) begin
      step();
      if (seq === 1'b1) high++;
      e = 16'(k + 2);
      checks++;
      if (seq !== 1'b1 || lout !== e || rout !== -e) begin
        errors++;
        $display("FAIL slide_win k=%0d: seq=%b l=%h r=%h, want 1/%h/%h", k, seq, lout, rout, e, -e);
      end
    end
    for (int j = 0; j < 3; j++) begin
      step();
      if (seq === 1'b1) high++;
    end
    checks++;
    if (high != TAPS || lout !== 16'(TAPS + 1) || rout !== -16'(TAPS + 1)) begin
      errors++;
      $display("FAIL slide_hold: high=%0d l=%h r=%h, want %0d/%h/%h", high, lout, rout, TAPS,
               16'(TAPS + 1), -16'(TAPS + 1));
    end
  endtask

  task automatic test_reset_mid;
    int high;
    high = 0;
    wr_big(TAPS + 2);
    repeat (3) step();
    checks++;
    if (seq !== 1'b1) begin errors++; $display("FAIL rmid_pre: seq=%b want 1", seq); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (seq !== 1'b0 || lout !== 16'h0000 || rout !== 16'h0000 || ovr !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: seq=%b l=%h r=%h ovr=%b, want 0/0000/0000/0", seq, lout, rout, ovr);
    end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 1; i < TAPS; i++) begin
      wr_big(i + 500);
      if (seq === 1'b1) high++;
    end
    repeat (4) begin
      step();
      if (seq === 1'b1) high++;
    end
    checks++;
    if (high != 0) begin errors++; $display("FAIL rmid_refill: seq high %0d cycles, want 0", high); end
  endtask

  task automatic test_wrap;
    logic [15:0] e;
    for (int n = 1; n <= 12; n++) begin
      wr_small(n + 9);
      checks++;
      if (s_seq !== 1'b0) begin errors++; $display("FAIL wrap_t1 n=%0d: seq=%b want 0", n, s_seq); end
      step();
      checks++;
      if (s_seq !== 1'b0) begin errors++; $display("FAIL wrap_t2 n=%0d: seq=%b want 0", n, s_seq); end
      for (int k = 0; k < S_TAPS; k++) begin
        step();
        e = 16'(n + 9 - 4 + k);
        checks++;
        if (n >= S_TAPS) begin
          if (s_seq !== 1'b1 || s_lout !== e || s_rout !== e + 16'd100) begin
            errors++;
            $display("FAIL wrap_win n=%0d k=%0d: seq=%b l=%0d r=%0d, want 1/%0d/%0d", n, k, s_seq,
                     s_lout, s_rout, e, e + 16'd100);
          end
        end else begin
          if (s_seq !== 1'b0) begin errors++; $display("FAIL wrap_fill n=%0d: seq=%b want 0", n, s_seq); end
        end
      end
      step();
      checks++;
      if (s_seq !== 1'b0) begin errors++; $display("FAIL wrap_end n=%0d: seq=%b want 0", n, s_seq); end
      repeat (2) step();
    end
  endtask

  task automatic test_overrun;
    logic [15:0] exp_a [5];
    logic [15:0] exp_b [5];
    exp_a = '{16'd18, 16'd19, 16'd20, 16'd21, 16'd30};
    exp_b = '{16'd19, 16'd20, 16'd21, 16'd30, 16'd32};
    wr_small(30);
    step();
    step();
    checks++;
    if (s_seq !== 1'b1 || s_lout !== exp_a[0] || s_ovr !== 1'b0) begin
      errors++; $display("FAIL ovr_k0: seq=%b l=%0d ovr=%b, want 1/%0d/0", s_seq, s_lout, s_ovr, exp_a[0]);
    end
    wr_small(31);
    checks++;
    if (s_ovr !== 1'b1 || s_seq !== 1'b1 || s_lout !== exp_a[1]) begin
      errors++; $display("FAIL ovr_pulse: ovr=%b seq=%b l=%0d, want 1/1/%0d", s_ovr, s_seq, s_lout, exp_a[1]);
    end
    for (int k = 2; k < S_TAPS; k++) begin
      step();
      checks++;
      if (s_ovr !== 1'b0 || s_seq !== 1'b1 || s_lout !== exp_a[k]) begin
        errors++;
        $display("FAIL ovr_win k=%0d: ovr=%b seq=%b l=%0d, want 0/1/%0d", k, s_ovr, s_seq, s_lout, exp_a[k]);
      end
    end
    repeat (3) step();
    wr_small(32);
    step();
    for (int k = 0; k < S_TAPS; k++) begin
      step();
      checks++;
      if (s_seq !== 1'b1 || s_lout !== exp_b[k]) begin
        errors++; $display("FAIL ovr_next k=%0d: seq=%b l=%0d, want 1/%0d", k, s_seq, s_lout, exp_b[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_c [5];
    logic [15:0] exp_d [5];
    exp_c = '{16'd20, 16'd21, 16'd30, 16'd32, 16'd40};
    exp_d = '{16'd21, 16'd30, 16'd32, 16'd40, 16'd41};
    step();
    checks++;
    if (s_seq !== 1'b0) begin errors++; $display("FAIL b2b_fall: seq=%b want 0", s_seq); end
    wr_small(40);
    checks++;
    if (s_ovr !== 1'b0 || s_seq !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: ovr=%b seq=%b, want 0/0", s_ovr, s_seq);
    end
    step();
    for (int k = 0; k < S_TAPS; k++) begin
      step();
      checks++;
      if (s_seq !== 1'b1 || s_lout !== exp_c[k]) begin
        errors++; $display("FAIL b2b_win k=%0d: seq=%b l=%0d, want 1/%0d", k, s_seq, s_lout, exp_c[k]);
      end
    end
    wr_small(41);
    checks++;
    if (s_ovr !== 1'b0 || s_seq !== 1'b0 || s_lout !== 16'd40) begin
      errors++; $display("FAIL b2b_edge: ovr=%b seq=%b l=%0d, want 0/0/40", s_ovr, s_seq, s_lout);
    end
    step();
    for (int k = 0; k < S_TAPS; k++) begin
      step();
      checks++;
      if (s_seq !== 1'b1 || s_lout !== exp_d[k]) begin
        errors++; $display("FAIL b2b_win2 k=%0d: seq=%b l=%0d, want 1/%0d", k, s_seq, s_lout, exp_d[k]);
      end
    end
    step();
    checks++;
    if (s_seq !== 1'b0 || s_lout !== 16'd41) begin
      errors++; $display("FAIL b2b_end: seq=%b l=%0d, want 0/41", s_seq, s_lout);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    wrt    = 1'b0;
    lft    = 16'h0000;
    rght   = 16'h0000;
    s_wrt  = 1'b0;
    s_lft  = 16'h0000;
    s_rght = 16'h0000;
    test_reset();
    test_fill();
    test_sliding();
    test_reset_mid();
    test_wrap();
    test_overrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
